ema_ctrl: RTL and testbench
===========================

# ema_ctrl

EMA sequencer that sits directly upstream of the two-mode ALU (ADD/MULT, one-register latency). It accepts one signed sample plus a smoothing coefficient per transaction and computes y[n] = alpha·x[n] + (1−alpha)·y[n−1] in Q1.15. It issues two MULT operations and one ADD to the ALU, rescales and saturates the result, and holds y[n−1] internally.

## Interface
- Win, 16, sample/result width; fractional bits fixed at Win−1 (Q1.15)
- Wout, 32, ALU result width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- sample_i  in  Win  signed input sample x[n]
- alpha_i  in  Win+1  signed coefficient; 32768 = 1.0
- valid_i  in  1  sample/alpha valid; accepted when valid_i & ready_o
- ready_o  out  1  high only in IDLE
- alu_op1_o  out  Win  signed ALU operand 1
- alu_op2_o  out  Win+1  signed ALU operand 2
- alu_mode_o  out  2  0 = IDLE, 1 = ADD, 2 = MULT
- alu_valid_o  out  1  operation issue strobe
- alu_res_i  in  Wout  signed ALU result
- alu_valid_i  in  1  ALU result valid
- y_o  out  Win  signed filter output, held between results
- valid_o  out  1  one-cycle pulse when y_o updates
- err_o  out  1  sticky: ALU result valid missing in a capture state

## Operation
- States: IDLE → MA → MB → WB → ADD → WADD → IDLE.
- IDLE: ready_o=1. On acceptance, latch x_r=sample_i and a_r=clamp(alpha_i, 0, 32768). Compute b_r=32768−a_r.
- First accepted sample after reset: a_r is forced to 32768 and b_r to 0, so y=x exactly. The first flag clears on that acceptance.
- MA: issue MULT with op1=x_r, op2=a_r, alu_valid_o=1.
- MB: issue MULT with op1=y_r, op2=b_r. Capture p1=alu_res_i[30:15] (arithmetic >>>15).
- WB: alu_mode_o=IDLE, alu_valid_o=0. Capture p2=alu_res_i[30:15].
- ADD: issue ADD with op1=p1, op2=sign-extend(p2).
- WADD: take alu_res_i, saturate to [−32768, 32767], write to y_r/y_o, and set valid_o for the next cycle.
- Rescaling is truncation (floor), with no rounding.
- In IDLE and WB: alu_op1_o=0, alu_op2_o=0, alu_mode_o=0.
- In capture states (MB, WB, WADD), alu_valid_i=0 sets err_o. The data is still captured and the sequence continues.
- err_o clears only on rst.
- valid_i while not in IDLE is ignored; upstream must hold its data until ready_o is high.
- alpha_i and sample_i are sampled only at acceptance.

## Timing
- Acceptance at cycle c0 (edge ending c0). MA in c1, MB in c2, WB in c3, ADD in c4, WADD in c5.
- In c6: y_o is valid with valid_o=1, and the FSM is in IDLE with ready_o=1, so it can accept in c6.
- Latency is 6 cycles; throughput is one sample per 6 cycles.
- ALU latency is fixed at 1: the result of an op issued in cycle k is read in cycle k+1.
- Reset values:
  - ready_o=1; y_o=0; valid_o=0; err_o=0
  - alu_op1_o=0, alu_op2_o=0, alu_mode_o=0, alu_valid_o=0
  - y_r=0; first flag set; state IDLE
- Reset mid-sequence aborts the transaction: no valid_o, all of the above reset values apply, and the first flag is re-armed.
- rst has priority over acceptance in the same cycle.

## Test plan
- Reset response: assert rst for 2 cycles, then release. Required: ready_o=1 and every other output 0; no alu_valid_o while idle.
- First-sample bypass: after reset, x=1000, alpha=8192. Required:
  - MULT ops (1000, 32768) then (0, 0), then ADD (1000, 0)
  - y_o=1000 and valid_o in c0+6
- Nominal update with y_prev=1000: x=2000, alpha=16384. Required: p1=1000, p2=500, y_o=1500 at c0+6. Also drive valid_i high throughout and confirm exactly one acceptance per 6 cycles.
- Truncation with y_prev=1500: x=−1, alpha=1. Required: p1=−1, p2=1499, y_o=1498.
- Clamping and saturation:
  - alpha_i=40000 must give y_o=x.
  - alpha_i=−5 must give y_o=y_prev.
  - Forcing alu_res_i=40000 in WADD must give y_o=32767.
- Faults:
  - Drop alu_valid_i in MB: err_o rises and stays high.
  - Assert rst during ADD: no valid_o, y_o=0. The next sample is then bypassed (y=x).

Source files
------------

// File: rtl/ema_ctrl.sv
// ema_ctrl: exponential moving average sequencer in Q1.15.
// Computes y[n] = alpha*x[n] + (1-alpha)*y[n-1] by driving an external
// two-mode ALU (ADD/MULT, one-register latency): two MULTs, then one ADD,
// then saturates the sum into the held output y.
module ema_ctrl #(
    parameter int Win  = 16,
    parameter int Wout = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [Win-1:0]  sample_i,
    input  logic signed [Win:0]    alpha_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic signed [Win-1:0]  alu_op1_o,
    output logic signed [Win:0]    alu_op2_o,
    output logic [1:0]             alu_mode_o,
    output logic                   alu_valid_o,
    input  logic signed [Wout-1:0] alu_res_i,
    input  logic                   alu_valid_i,
    output logic signed [Win-1:0]  y_o,
    output logic                   valid_o,
    output logic                   err_o
);

    // 1.0 in Q1.15, carried in the Win+1 bit coefficient width
    localparam logic signed [Win:0]    ONE    = {2'b01, {(Win-1){1'b0}}};
    localparam logic signed [Wout-1:0] SAT_HI = Wout'((1 <<< (Win-1)) - 1);
    localparam logic signed [Wout-1:0] SAT_LO = -SAT_HI - 1;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_MULT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MA,
        S_MB,
        S_WB,
        S_ADD,
        S_WADD
    } state_t;

    state_t state, state_n;

    logic                  first_r;
    logic                  err_r;
    logic                  valid_r;
    logic signed [Win-1:0] y_r;
    logic signed [Win-1:0] x_r;
    logic signed [Win:0]   a_r;
    logic signed [Win:0]   b_r;
    logic signed [Win-1:0] p1_r;
    logic signed [Win-1:0] p2_r;

    logic                  accept;
    logic                  capture;
    logic signed [Win:0]   a_sel;

    // Limit the coefficient to [0, 1.0]
    function automatic logic signed [Win:0] clamp_alpha(input logic signed [Win:0] a);
        if (a < 0)
            return '0;
        else if (a > ONE)
            return ONE;
        else
            return a;
    endfunction

    // Q2.30 product back to Q1.15 by truncation (arithmetic shift by Win-1)
    function automatic logic signed [Win-1:0] rescale(input logic signed [Wout-1:0] r);
        return r[2*Win-2:Win-1];
    endfunction

    // Clip a full-width ALU sum into the signed Win-bit range
    function automatic logic signed [Win-1:0] saturate(input logic signed [Wout-1:0] r);
        if (r > SAT_HI)
            return SAT_HI[Win-1:0];
        else if (r < SAT_LO)
            return SAT_LO[Win-1:0];
        else
            return r[Win-1:0];
    endfunction

    assign accept  = (state == S_IDLE) && valid_i;
    assign capture = (state == S_MB) || (state == S_WB) || (state == S_WADD);
    // First sample after reset bypasses smoothing so y starts at x exactly
    assign a_sel   = first_r ? ONE : clamp_alpha(alpha_i);

    // Control state, output history and sticky error; all cleared by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            first_r <= 1'b1;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            y_r     <= '0;
        end else begin
            state   <= state_n;
            valid_r <= (state == S_WADD);
            if (accept)
                first_r <= 1'b0;
            if (capture && !alu_valid_i)
                err_r <= 1'b1;
            if (state == S_WADD)
                y_r <= saturate(alu_res_i);
        end
    end

    // Operand latches and partial products; qualified by state, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            x_r <= sample_i;
            a_r <= a_sel;
            b_r <= ONE - a_sel;
        end
        if (state == S_MB)
            p1_r <= rescale(alu_res_i);
        if (state == S_WB)
            p2_r <= rescale(alu_res_i);
    end

    // Next-state sequencing and ALU command decode
    always_comb begin
        state_n     = state;
        ready_o     = 1'b0;
        alu_op1_o   = '0;
        alu_op2_o   = '0;
        alu_mode_o  = MODE_IDLE;
        alu_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i)
                    state_n = S_MA;
            end
            S_MA: begin
                alu_op1_o   = x_r;
                alu_op2_o   = a_r;
                alu_mode_o  = MODE_MULT;
                alu_valid_o = 1'b1;
                state_n     = S_MB;
            end
            S_MB: begin
                alu_op1_o   = y_r;
                alu_op2_o   = b_r;
                alu_mode_o  = MODE_MULT;
                alu_valid_o = 1'b1;
                state_n     = S_WB;
            end
            S_WB: begin
                state_n = S_ADD;
            end
            S_ADD: begin
                alu_op1_o   = p1_r;
                alu_op2_o   = {p2_r[Win-1], p2_r};
                alu_mode_o  = MODE_ADD;
                alu_valid_o = 1'b1;
                state_n     = S_WADD;
            end
            S_WADD: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign y_o     = y_r;
    assign valid_o = valid_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_ema_ctrl.sv
// Testbench for ema_ctrl: behavioural ALU responder plus an arithmetic
// reference of the EMA recurrence, with randomized and directed cases.
module tb_ema_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sample_i = '0;
    logic signed [16:0] alpha_i = '0;
    logic               valid_i = 1'b0;
    logic               ready_o;
    logic signed [15:0] alu_op1_o;
    logic signed [16:0] alu_op2_o;
    logic [1:0]         alu_mode_o;
    logic               alu_valid_o;
    logic signed [31:0] alu_res_i;
    logic               alu_valid_i;
    logic signed [15:0] y_o;
    logic               valid_o;
    logic               err_o;

    // ALU behaviour and fault injection
    logic signed [31:0] alu_res_m = '0;
    logic               alu_vld_m = 1'b0;
    logic               force_en = 1'b0;
    logic signed [31:0] force_val = '0;
    logic               drop_vld = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    int  y_m = 0;
    logic first_m = 1'b1;

    // per-cycle capture of one transaction (index = cycle after acceptance)
    int   c_mode [1:6];
    int   c_op1  [1:6];
    int   c_op2  [1:6];
    logic c_av   [1:6];
    logic c_vo   [1:6];
    int   c_y    [1:6];
    logic c_err  [1:6];
    logic c_rdy  [1:6];

    // expected values of the most recent modelled transaction
    int e_a, e_b, e_p1, e_p2, e_yprev, e_y;

    ema_ctrl #(.Win(16), .Wout(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_i   (sample_i),
        .alpha_i    (alpha_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .alu_op1_o  (alu_op1_o),
        .alu_op2_o  (alu_op2_o),
        .alu_mode_o (alu_mode_o),
        .alu_valid_o(alu_valid_o),
        .alu_res_i  (alu_res_i),
        .alu_valid_i(alu_valid_i),
        .y_o        (y_o),
        .valid_o    (valid_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // One-register ALU: result of the op issued this cycle appears next cycle
    always @(posedge clk) begin
        alu_vld_m <= alu_valid_o;
        if (alu_mode_o == 2'd2)
            alu_res_m <= int'(alu_op1_o) * int'(alu_op2_o);
        else if (alu_mode_o == 2'd1)
            alu_res_m <= int'(alu_op1_o) + int'(alu_op2_o);
        else
            alu_res_m <= 0;
    end

    assign alu_res_i   = force_en ? force_val : alu_res_m;
    assign alu_valid_i = alu_vld_m & ~drop_vld;

    // EMA reference: y = sat(floor(x*a/2^15) + floor(y*b/2^15))
    task automatic model_txn(input int x, input int alpha);
        int a;
        if (first_m)
            a = 32768;
        else if (alpha < 0)
            a = 0;
        else if (alpha > 32768)
            a = 32768;
        else
            a = alpha;
        e_a     = a;
        e_b     = 32768 - a;
        e_yprev = y_m;
        e_p1    = (x * e_a) >>> 15;
        e_p2    = (y_m * e_b) >>> 15;
        e_y     = e_p1 + e_p2;
        if (e_y > 32767)  e_y = 32767;
        if (e_y < -32768) e_y = -32768;
        y_m     = e_y;
        first_m = 1'b0;
    endtask

    // Present one sample, wait for acceptance, record cycles c1..c6 and
    // optionally inject a fault at a given cycle index.
    task automatic send(input int x, input int alpha, input int drop_k,
                        input int force_k, input int fval, input int rst_k);
        int n;
        n = 0;
        @(negedge clk);
        sample_i = 16'(x);
        alpha_i  = 17'(alpha);
        valid_i  = 1'b1;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 20) begin
            n_bad++;
            $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles, required 1", n);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) valid_i = 1'b0;
            c_mode[k] = int'(alu_mode_o);
            c_op1[k]  = int'(alu_op1_o);
            c_op2[k]  = int'(alu_op2_o);
            c_av[k]   = alu_valid_o;
            c_vo[k]   = valid_o;
            c_y[k]    = int'(y_o);
            c_err[k]  = err_o;
            c_rdy[k]  = ready_o;
            drop_vld  = (k == drop_k);
            force_en  = (k == force_k);
            force_val = fval;
            rst       = (k == rst_k);
        end
        drop_vld = 1'b0;
        force_en = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready_o, valid_o, err_o, alu_valid_o, alu_mode_o} !== 6'b100000 ||
            alu_op1_o !== 0 || alu_op2_o !== 0 || y_o !== 0) begin
            n_bad++;
            $display("FAIL reset_in: rdy=%b vo=%b err=%b av=%b mode=%0d op1=%0d op2=%0d y=%0d, required rdy=1 rest 0",
                     ready_o, valid_o, err_o, alu_valid_o, alu_mode_o, alu_op1_o, alu_op2_o, y_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ready_o !== 1'b1 || alu_valid_o !== 1'b0 || valid_o !== 1'b0 || y_o !== 0) begin
                n_bad++;
                $display("FAIL reset_idle: rdy=%b av=%b vo=%b y=%0d, required 1/0/0/0",
                         ready_o, alu_valid_o, valid_o, y_o);
            end
        end
        y_m = 0;
        first_m = 1'b1;
    endtask

    task automatic test_first_bypass();
        model_txn(1000, 8192);
        send(1000, 8192, 0, 0, 0, 0);
        n_cmp++;
        if (c_mode[1] !== 2 || c_op1[1] !== 1000 || c_op2[1] !== 32768 || c_av[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_ma: mode=%0d op1=%0d op2=%0d av=%b, required 2 1000 32768 1",
                     c_mode[1], c_op1[1], c_op2[1], c_av[1]);
        end
        n_cmp++;
        if (c_mode[2] !== 2 || c_op1[2] !== 0 || c_op2[2] !== 0 || c_av[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_mb: mode=%0d op1=%0d op2=%0d, required 2 0 0",
                     c_mode[2], c_op1[2], c_op2[2]);
        end
        n_cmp++;
        if (c_mode[4] !== 1 || c_op1[4] !== 1000 || c_op2[4] !== 0) begin
            n_bad++;
            $display("FAIL bypass_add: mode=%0d op1=%0d op2=%0d, required 1 1000 0",
                     c_mode[4], c_op1[4], c_op2[4]);
        end
        n_cmp++;
        if (c_y[6] !== 1000 || c_vo[6] !== 1'b1 || c_vo[5] !== 1'b0 || c_rdy[6] !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_out: y=%0d vo5=%b vo6=%b rdy6=%b, required y=1000 vo5=0 vo6=1 rdy6=1",
                     c_y[6], c_vo[5], c_vo[6], c_rdy[6]);
        end
    endtask

    task automatic test_nominal();
        model_txn(2000, 16384);
        send(2000, 16384, 0, 0, 0, 0);
        n_cmp++;
        if (c_op1[4] !== 1000 || c_op2[4] !== 500 || c_y[6] !== 1500 || c_vo[6] !== 1'b1) begin
            n_bad++;
            $display("FAIL nominal: p1=%0d p2=%0d y=%0d vo=%b, required p1=1000 p2=500 y=1500 vo=1",
                     c_op1[4], c_op2[4], c_y[6], c_vo[6]);
        end
    endtask

    task automatic test_truncation();
        model_txn(-1, 1);
        send(-1, 1, 0, 0, 0, 0);
        n_cmp++;
        if (c_op1[4] !== -1 || c_op2[4] !== 1499 || c_y[6] !== 1498) begin
            n_bad++;
            $display("FAIL truncation: p1=%0d p2=%0d y=%0d, required p1=-1 p2=1499 y=1498",
                     c_op1[4], c_op2[4], c_y[6]);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        acc = 0;
        @(negedge clk);
        sample_i = 16'sd3000;
        alpha_i  = 17'sd10000;
        valid_i  = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (ready_o) acc++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        for (int i = 0; i < 6; i++) model_txn(3000, 10000);
        n_cmp++;
        if (acc !== 6) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d acceptances in 36 cycles, required 6", acc);
        end
        n_cmp++;
        if (int'(y_o) !== y_m || valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_value: y=%0d vo=%b, required y=%0d vo=1", y_o, valid_o, y_m);
        end
    endtask

    task automatic test_clamp_sat();
        model_txn(-7000, 40000);
        send(-7000, 40000, 0, 0, 0, 0);
        n_cmp++;
        if (c_y[6] !== -7000) begin
            n_bad++;
            $display("FAIL clamp_high: y=%0d, required -7000", c_y[6]);
        end
        model_txn(12345, -5);
        send(12345, -5, 0, 0, 0, 0);
        n_cmp++;
        if (c_y[6] !== -7000 || c_op2[1] !== 0 || c_op2[2] !== 32768) begin
            n_bad++;
            $display("FAIL clamp_low: y=%0d a=%0d b=%0d, required y=-7000 a=0 b=32768",
                     c_y[6], c_op2[1], c_op2[2]);
        end
        model_txn(5, 5);
        y_m = 32767;
        send(5, 5, 0, 5, 40000, 0);
        n_cmp++;
        if (c_y[6] !== 32767 || c_vo[6] !== 1'b1) begin
            n_bad++;
            $display("FAIL saturate_hi: y=%0d vo=%b, required 32767 1", c_y[6], c_vo[6]);
        end
        model_txn(5, 5);
        y_m = -32768;
        send(5, 5, 0, 5, -50000, 0);
        n_cmp++;
        if (c_y[6] !== -32768) begin
            n_bad++;
            $display("FAIL saturate_lo: y=%0d, required -32768", c_y[6]);
        end
    endtask

    task automatic test_random();
        int x, al;
        for (int t = 0; t < 24; t++) begin
            x  = int'($urandom_range(0, 65535)) - 32768;
            al = int'($urandom_range(0, 80000)) - 40000;
            if (t == 3) al = 0;
            if (t == 5) al = 32768;
            model_txn(x, al);
            send(x, al, 0, 0, 0, 0);
            n_cmp++;
            if (c_mode[1] !== 2 || c_op1[1] !== x || c_op2[1] !== e_a ||
                c_mode[2] !== 2 || c_op1[2] !== e_yprev || c_op2[2] !== e_b ||
                c_mode[3] !== 0 || c_av[3] !== 1'b0 ||
                c_mode[4] !== 1 || c_op1[4] !== e_p1 || c_op2[4] !== e_p2) begin
                n_bad++;
                $display("FAIL rand_ops[%0d]: ma=(%0d,%0d) mb=(%0d,%0d) add=(%0d,%0d), required ma=(%0d,%0d) mb=(%0d,%0d) add=(%0d,%0d)",
                         t, c_op1[1], c_op2[1], c_op1[2], c_op2[2], c_op1[4], c_op2[4],
                         x, e_a, e_yprev, e_b, e_p1, e_p2);
            end
            n_cmp++;
            if (c_y[6] !== e_y || c_vo[6] !== 1'b1 || c_vo[5] !== 1'b0 || c_err[6] !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_out[%0d]: y=%0d vo5=%b vo6=%b err=%b, required y=%0d vo5=0 vo6=1 err=0",
                         t, c_y[6], c_vo[5], c_vo[6], c_err[6], e_y);
            end
        end
    endtask

    task automatic test_err_drop();
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pre: err=%b, required 0", err_o);
        end
        model_txn(4321, 20000);
        send(4321, 20000, 2, 0, 0, 0);
        n_cmp++;
        if (c_err[2] !== 1'b0 || c_err[3] !== 1'b1 || c_err[6] !== 1'b1 || c_y[6] !== e_y) begin
            n_bad++;
            $display("FAIL err_rise: err2=%b err3=%b err6=%b y=%0d, required 0 1 1 y=%0d",
                     c_err[2], c_err[3], c_err[6], c_y[6], e_y);
        end
        model_txn(-300, 30000);
        send(-300, 30000, 0, 0, 0, 0);
        n_cmp++;
        if (c_err[6] !== 1'b1 || c_y[6] !== e_y) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b y=%0d, required err=1 y=%0d", c_err[6], c_y[6], e_y);
        end
    endtask

    task automatic test_rst_abort();
        send(9000, 16384, 0, 0, 0, 4);
        y_m = 0;
        first_m = 1'b1;
        n_cmp++;
        if (c_vo[5] !== 1'b0 || c_vo[6] !== 1'b0 || c_y[6] !== 0 || c_err[6] !== 1'b0 ||
            c_rdy[5] !== 1'b1 || c_av[5] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_abort: vo5=%b vo6=%b y=%0d err=%b rdy5=%b av5=%b, required 0 0 0 0 1 0",
                     c_vo[5], c_vo[6], c_y[6], c_err[6], c_rdy[5], c_av[5]);
        end
        model_txn(-1234, 100);
        send(-1234, 100, 0, 0, 0, 0);
        n_cmp++;
        if (c_y[6] !== -1234 || c_op2[1] !== 32768 || c_vo[6] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_rearm: y=%0d a=%0d vo=%b, required y=-1234 a=32768 vo=1",
                     c_y[6], c_op2[1], c_vo[6]);
        end
    endtask

    initial begin
        test_reset();
        test_first_bypass();
        test_nominal();
        test_truncation();
        test_back_to_back();
        test_clamp_sat();
        test_random();
        test_err_drop();
        test_rst_abort();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
